div_seq8: RTL and testbench
===========================

DIV_SEQ8 -- requirements
Module: div_seq8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width; only 8 is required to be supported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, 8, unsigned numerator; sampled with start.
REQ-006 SHALL have port divisor, input, 8, unsigned denominator; sampled with start.
REQ-007 SHALL have port quotient, output, 8, registered result.
REQ-008 SHALL have port remainder, output, 8, registered result.
REQ-009 SHALL have port busy, output, 1, high while in RUN.
REQ-010 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port div_by_zero, output, 1, flag for a zero divisor, valid with done and held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at edge E0, latch the operands, clear the working remainder, load the dividend into the shift register, clear the 3-bit iteration count, and go to RUN.
REQ-014 SHALL, in IDLE with start=1 and divisor=0 at E0, go directly to DONE with quotient=8'hFF, remainder=dividend and div_by_zero=1, so that done is high for the cycle after E0.
REQ-015 SHALL perform one restoring step per RUN cycle: shift {rem,q} left by one, compute trial = shifted_rem - divisor at 9 bits, and if trial[8]==0 set rem=trial[7:0] and q[0]=1, else keep shifted_rem and set q[0]=0.
REQ-016 SHALL execute exactly 8 iterations on edges E1..E8, move to DONE at E8, and hold done=1 for exactly the cycle between E8 and E9 (latency 8 cycles).
REQ-017 SHALL go from DONE to IDLE unconditionally on the next edge; start in DONE SHALL be ignored.
REQ-018 SHALL ignore start while in RUN, with the operands in flight unaffected.
REQ-019 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.
REQ-020 SHALL leave quotient and remainder unspecified during RUN; the bench checks them only when done=1.
REQ-021 SHALL clear div_by_zero on every accepted start with a nonzero divisor.
REQ-022 SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor for every divisor != 0.

Reset
REQ-023 SHALL, while reset_n=0, immediately force state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 and iteration count=0.
REQ-024 SHALL, if reset is asserted mid-RUN, abort the operation, produce no done pulse, and be ready to accept start on the first edge after release.

Structure
REQ-025 SHALL place the WIDTH default and the IDLE/RUN/DONE state encodings (2-bit) in a shared include header for all sequential arithmetic blocks.
REQ-026 SHALL factor the restoring step (shift, 9-bit trial subtract, select) into one combinational sub-module, div_step, instantiated once.
REQ-027 SHALL register all outputs, with no combinational path from any input to any output.

Verification
REQ-028 SHALL cover: dividend=100, divisor=7, start at E0 -> done at the cycle after E8, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL cover: dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-030 SHALL cover: dividend=5, divisor=0 -> done in the cycle after E0, quotient=8'hFF, remainder=5, div_by_zero=1, busy never high.
REQ-031 SHALL cover: start pulsed at E3 with new operands during RUN of 200/9 -> result quotient=22, remainder=2 unchanged, and exactly one done pulse.
REQ-032 SHALL cover: reset_n driven low at E4 of a division -> all outputs 0 immediately and no done; after release, 17/17 -> quotient=1, remainder=0.
REQ-033 SHALL cover: a random sweep of 1000 operand pairs checked against REQ-022, with done width always exactly 1 cycle.

Source files
------------

// File: rtl/div_seq8_pkg.sv
// Shared definitions for the sequential arithmetic blocks:
// the default operand width and the 2-bit controller state encoding.
package div_seq8_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,q} left, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shifted remainder keeps the carried-out bit so the 9-bit trial sign is exact.
  assign shifted  = {rem, q[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_seq8.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH cycles per division,
// with an immediate divide-by-zero result and fully registered outputs.
module div_seq8
  import div_seq8_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .q        (sh_q),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvsr_d = divisor;
          rem_d  = '0;
          sh_d   = dividend;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            dbz_d   = 1'b0;
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        sh_d  = step_q;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quo_d   = step_q;
          rmd_d   = step_rem;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status flags are decoded from the next state so they leave the chip from flops.
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      sh_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq8.sv
// Directed and random bench for div_seq8 against a cycle-level arithmetic model.
module tb_div_seq8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  div_seq8 #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 8 busy cycles after an accepted nonzero-divisor start, then one done cycle.
  int       m_busy_left = 0;
  bit       m_done = 1'b0;
  bit [7:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;
  bit       m_dbz = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy_left = 0;
      m_done = 1'b0;
      m_q = '0;
      m_r = '0;
      m_dbz = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_done = 1'b1;
        m_q = pend_q;
        m_r = pend_r;
      end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1'b1;
        m_q = 8'hFF;
        m_r = dividend;
        m_dbz = 1'b1;
      end else begin
        m_busy_left = 8;
        pend_q = dividend / divisor;
        pend_r = dividend % divisor;
        m_dbz = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", int'(busy), int'(m_busy_left > 0));
    check("done", int'(done), int'(m_done));
    check("div_by_zero", int'(div_by_zero), int'(m_dbz));
    if (m_busy_left == 0) begin
      check("quotient", int'(quotient), int'(m_q));
      check("remainder", int'(remainder), int'(m_r));
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in idle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output logic [7:0] q,
                         output logic [7:0] r, output logic z, output int lat);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    q = '0;
    r = '0;
    z = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  logic [7:0] q, r;
  logic       z;
  int         lat;
  int         pulses;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_quotient", int'(quotient), 0);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_div(8'd100, 8'd7, q, r, z, lat);
    check("100/7_latency", lat, 8);
    check("100/7_q", int'(q), 14);
    check("100/7_r", int'(r), 2);
    check("100/7_dbz", int'(z), 0);

    run_div(8'd255, 8'd1, q, r, z, lat);
    check("255/1_q", int'(q), 255);
    check("255/1_r", int'(r), 0);
    run_div(8'd3, 8'd10, q, r, z, lat);
    check("3/10_q", int'(q), 0);
    check("3/10_r", int'(r), 3);

    run_div(8'd5, 8'd0, q, r, z, lat);
    check("5/0_latency", lat, 0);
    check("5/0_q", int'(q), 255);
    check("5/0_r", int'(r), 5);
    check("5/0_dbz", int'(z), 1);
    check("5/0_dbz_held", int'(div_by_zero), 1);

    // Start re-pulsed at E3 with different operands must not disturb 200/9.
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        pulses++;
        q = quotient;
        r = remainder;
      end
      @(negedge clk);
    end
    check("200/9_pulses", pulses, 1);
    check("200/9_q", int'(q), 22);
    check("200/9_r", int'(r), 2);

    // Reset asserted just after E4 aborts the division.
    start = 1'b1;
    dividend = 8'd123;
    divisor = 8'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_div(8'd17, 8'd17, q, r, z, lat);
    check("17/17_latency", lat, 8);
    check("17/17_q", int'(q), 1);
    check("17/17_r", int'(r), 0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_div(a, b, q, r, z, lat);
      check("sweep_latency", lat, 8);
      check("sweep_identity", int'(q) * int'(b) + int'(r), int'(a));
      check("sweep_rem_lt_div", int'(r < b), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
